twiddle_gen: RTL and testbench

- Parametrised twiddle-factor generator for the FFT datapath. Produces W = exp(-j*2*pi*k/N) for a runtime-selectable size N = 2^log2n, up to N_MAX = 2^MAX_LOG2N.
- Stores only a quarter-wave cosine table of N_MAX/4+1 entries and rebuilds all four quadrants by index mirroring and sign swapping.
- Has a valid/ready pipeline with backpressure and a conjugate mode for the inverse FFT. Sits between the FFT address sequencer and the butterfly multiplier.

---
 rtl/twiddle_gen.sv | 155 +++++++++++++++
 tb/tb_twiddle_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator: W = exp(-j*2*pi*k/N) for runtime N = 2^log2n.
// A quarter-wave cosine table is generated at elaboration by a constant
// function; all four quadrants are rebuilt by index mirroring and sign swaps.
// Three-stage valid/ready pipeline with a single global advance signal.
module twiddle_gen #(
  parameter int MAX_LOG2N = 9,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           log2n,
  input  logic                 inverse,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_LOG2N-1:0] k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    dout_real,
  output logic [DATA_W-1:0]    dout_imag
);

  localparam int unsigned QW = MAX_LOG2N - 2;
  localparam int unsigned M  = 1 << QW;
  localparam longint ONE_Q30 = 64'sd1 << 30;
  localparam longint PI_Q30  = 64'sd3373259426;

  // Entry r = round((2^(DATA_W-1)-1) * cos(2*pi*r/N_MAX)), r = 0..M, evaluated
  // with a Q30 fixed-point Taylor series (angles never exceed pi/2).
  function automatic logic [(M+1)*DATA_W-1:0] build_quarter_table();
    logic [(M+1)*DATA_W-1:0] tbl;
    longint x, x2, term, acc, fs, val;
    tbl = '0;
    fs  = (64'sd1 << (DATA_W - 1)) - 64'sd1;
    for (int unsigned r = 0; r <= M; r++) begin
      x    = (64'sd2 * PI_Q30 * longint'(r)) / longint'(4 * M);
      x2   = (x * x) / ONE_Q30;
      term = ONE_Q30;
      acc  = ONE_Q30;
      for (int unsigned n = 1; n <= 12; n++) begin
        term = -((term * x2) / ONE_Q30) / longint'((2 * n - 1) * (2 * n));
        acc  = acc + term;
      end
      if (acc < 0) acc = 0;
      val = (fs * acc + ONE_Q30 / 2) / ONE_Q30;
      tbl[r*DATA_W +: DATA_W] = DATA_W'(val);
    end
    return tbl;
  endfunction

  localparam logic [(M+1)*DATA_W-1:0] QTABLE = build_quarter_table();

  logic                 advance;
  logic [3:0]           eff_log2n;
  logic [3:0]           shamt;
  logic [MAX_LOG2N-1:0] idx;
  logic [QW:0]          mr;
  logic [DATA_W-1:0]    cos_v, sin_v;

  logic              v1_q, v1_d, inv1_q, inv1_d;
  logic [1:0]        q1_q, q1_d;
  logic [QW-1:0]     r1_q, r1_d;
  logic              v2_q, v2_d, inv2_q, inv2_d;
  logic [1:0]        q2_q, q2_d;
  logic [DATA_W-1:0] a2_q, a2_d, b2_q, b2_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign dout_real = dout_real_q;
  assign dout_imag = dout_imag_q;

  // Map size select to a table stride and scale k to a full-size index.
  always_comb begin
    eff_log2n = ((log2n < 4'd2) || (log2n > 4'(MAX_LOG2N))) ? 4'(MAX_LOG2N) : log2n;
    shamt     = 4'(MAX_LOG2N) - eff_log2n;
    idx       = (k & ({MAX_LOG2N{1'b1}} >> shamt)) << shamt;
    mr        = (QW+1)'(M) - {1'b0, r1_q};
  end

  // Rebuild (cos, sin) for the registered quadrant from the two table reads.
  always_comb begin
    cos_v = a2_q;
    sin_v = b2_q;
    case (q2_q)
      2'd0: begin cos_v = a2_q;  sin_v = b2_q;  end
      2'd1: begin cos_v = -b2_q; sin_v = a2_q;  end
      2'd2: begin cos_v = -a2_q; sin_v = -b2_q; end
      default: begin cos_v = b2_q; sin_v = -a2_q; end
    endcase
  end

  // Next-state for all stages; everything, including the table read, holds when stalled.
  always_comb begin
    v1_d        = v1_q;
    q1_d        = q1_q;
    r1_d        = r1_q;
    inv1_d      = inv1_q;
    v2_d        = v2_q;
    q2_d        = q2_q;
    inv2_d      = inv2_q;
    a2_d        = a2_q;
    b2_d        = b2_q;
    out_valid_d = out_valid_q;
    dout_real_d = dout_real_q;
    dout_imag_d = dout_imag_q;
    if (advance) begin
      v1_d        = in_valid;
      q1_d        = idx[MAX_LOG2N-1 -: 2];
      r1_d        = idx[QW-1:0];
      inv1_d      = inverse;
      v2_d        = v1_q;
      q2_d        = q1_q;
      inv2_d      = inv1_q;
      a2_d        = QTABLE[32'(r1_q) * DATA_W +: DATA_W];
      b2_d        = QTABLE[32'(mr) * DATA_W +: DATA_W];
      out_valid_d = v2_q;
      dout_real_d = cos_v;
      dout_imag_d = inv2_q ? sin_v : -sin_v;
    end
  end

  // Pipeline registers; reset clears every in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      q1_q        <= '0;
      r1_q        <= '0;
      inv1_q      <= 1'b0;
      v2_q        <= 1'b0;
      q2_q        <= '0;
      inv2_q      <= 1'b0;
      a2_q        <= '0;
      b2_q        <= '0;
      out_valid_q <= 1'b0;
      dout_real_q <= '0;
      dout_imag_q <= '0;
    end else begin
      v1_q        <= v1_d;
      q1_q        <= q1_d;
      r1_q        <= r1_d;
      inv1_q      <= inv1_d;
      v2_q        <= v2_d;
      q2_q        <= q2_d;
      inv2_q      <= inv2_d;
      a2_q        <= a2_d;
      b2_q        <= b2_d;
      out_valid_q <= out_valid_d;
      dout_real_q <= dout_real_d;
      dout_imag_q <= dout_imag_d;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (MAX_LOG2N=9, DATA_W=8).
module tb_twiddle_gen;

  logic              clk;
  logic              reset;
  logic [3:0]        log2n;
  logic              inverse;
  logic              in_valid;
  logic              in_ready;
  logic [8:0]        k;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] dout_real;
  logic signed [7:0] dout_imag;

  int errors = 0;
  int checks = 0;

  twiddle_gen #(.MAX_LOG2N(9), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .log2n     (log2n),
    .inverse   (inverse),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_real (dout_real),
    .dout_imag (dout_imag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [31:0] obs, input real exp);
    real d;
    d = real'(obs) - exp;
    checks++;
    assert (!$isunknown(obs) && d <= 1.0 && d >= -1.0) else begin
      errors++;
      $error("FAIL %s: got %0d expected %f (+/-1)", tag, obs, exp);
    end
  endtask

  // One isolated request with the pipeline empty; checks the 3-edge latency and the result.
  task automatic single(input string tag, input logic [3:0] l2, input logic inv,
                        input logic [8:0] kk, input int er, input int ei);
    log2n = l2; inverse = inv; k = kk; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk($sformatf("%s_in_ready", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("%s_lat1", tag), out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("%s_lat2", tag), out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("%s_lat3", tag), out_valid, 1);
    chk($sformatf("%s_re", tag), dout_real, er);
    chk($sformatf("%s_im", tag), dout_imag, ei);
    @(posedge clk); #1;
  endtask

  logic signed [7:0] rr [512];
  logic signed [7:0] ri [512];

  initial begin
    int sent, got;
    logic pv, pr;
    logic signed [7:0] pre, pim;
    real th;

    reset = 1'b1; log2n = 4'd9; inverse = 1'b0; in_valid = 1'b0; k = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_re", dout_real, 0);
    chk("rst_im", dout_imag, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", out_valid, 0);

    // Quadrant corners
    single("q0", 4'd9, 1'b0, 9'd0,   127,    0);
    single("q1", 4'd9, 1'b0, 9'd128,   0, -127);
    single("q2", 4'd9, 1'b0, 9'd256, -127,   0);
    single("q3", 4'd9, 1'b0, 9'd384,   0,  127);

    // Size scaling, conjugate, aliasing
    single("n8",      4'd3, 1'b0, 9'd1, 90, -90);
    single("n8_inv",  4'd3, 1'b1, 9'd1, 90,  90);
    single("n8_alias",4'd3, 1'b0, 9'd9, 90, -90);
    single("n16_q1",  4'd4, 1'b0, 9'd4,  0, -127);
    single("inv_q1",  4'd9, 1'b1, 9'd128, 0, 127);

    // Illegal sizes fall back to MAX_LOG2N
    single("l2_0",  4'd0,  1'b0, 9'd128, 0, -127);
    single("l2_1",  4'd1,  1'b0, 9'd128, 0, -127);
    single("l2_12", 4'd12, 1'b0, 9'd128, 0, -127);

    // Full sweep, back to back
    log2n = 4'd9; inverse = 1'b0; out_ready = 1'b1;
    sent = 0; got = 0;
    for (int c = 0; c < 700 && got < 512; c++) begin
      if (out_valid) begin
        rr[got] = dout_real;
        ri[got] = dout_imag;
        got++;
      end
      if (sent < 512) begin
        in_valid = 1'b1; k = 9'(sent); sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("sweep_count", got, 512);
    for (int i = 0; i < 512; i++) begin
      th = 2.0 * 3.14159265358979 * real'(i) / 512.0;
      chk_near($sformatf("sweep_re[%0d]", i), rr[i], 127.0 * $cos(th));
      chk_near($sformatf("sweep_im[%0d]", i), ri[i], -127.0 * $sin(th));
    end
    for (int i = 1; i < 128; i++) begin
      chk($sformatf("mirror[%0d]", i), rr[128-i], -ri[i]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure with random out_ready
    sent = 0; got = 0; pv = 1'b0; pr = 1'b1; pre = '0; pim = '0;
    for (int c = 0; c < 300 && got < 16; c++) begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_re", dout_real, pre);
        chk("hold_im", dout_imag, pim);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        in_valid = 1'b1; k = 9'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (out_valid && out_ready) begin
        th = 2.0 * 3.14159265358979 * real'(got) / 512.0;
        chk_near($sformatf("bp_re[%0d]", got), dout_real, 127.0 * $cos(th));
        chk_near($sformatf("bp_im[%0d]", got), dout_imag, -127.0 * $sin(th));
        got++;
      end
      if (in_valid && in_ready) sent++;
      pv = out_valid; pr = out_ready; pre = dout_real; pim = dout_imag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 16);
    chk("bp_no_extra", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with three requests in flight
    out_ready = 1'b1; log2n = 4'd9; inverse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; k = 9'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_re", dout_real, 0);
    chk("async_rst_im", dout_imag, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale", out_valid, 0);
    end
    single("post_rst", 4'd9, 1'b0, 9'd256, -127, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
